register_file_mp: RTL and testbench

//  Parametrised multi-port register file for the MiniMicro core; successor to the single-write, 2-read regfile.

---
 rtl/register_file_mp.sv | 136 +++++++++++++
 tb/tb_register_file_mp.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with PC alias, dual write ports and pending-load scoreboard
//
// Purpose:
//   Architectural registers R0..R(2^ADDR_W-1) with one index (PC_IDX) aliased
//   to the program counter. Reads of PC_IDX return pc + PC_OFFSET. Writes to
//   PC_IDX do not touch the array; they are reported as a PC write request on
//   the following cycle. A per-register pending bit tracks outstanding loads.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ra / rd / rd_busy   NUM_RD combinational read ports (address, data, pending)
//   pc                  current program counter
//   we0/wa0/wd0         write port 0 (ALU writeback), wins on address collision
//   we1/wa1/wd1         write port 1 (load writeback), clears the pending bit
//   pend_set/pend_addr  mark a register pending when a load issues
//   pc_wr_valid         one-cycle pulse after a write to PC_IDX
//   pc_wr_data          last PC write value, held until the next PC write
//   wr_collide          one-cycle pulse after both ports wrote the same address
//
// Configuration:
//   REGFILE_BYPASS_EN   when defined, same-cycle writes are forwarded to reads
//                       and a same-cycle port 1 write hides the pending bit.

module register_file_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_RD    = 2,
    parameter int PC_IDX    = 15,
    parameter int PC_OFFSET = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [DATA_W-1:0]        pc,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic                     pc_wr_valid,
    output logic [DATA_W-1:0]        pc_wr_data,
    output logic                     wr_collide
);

    localparam int                NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PC_OFF   = DATA_W'(PC_OFFSET);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                pc_wr_valid_q, pc_wr_valid_d;
    logic [DATA_W-1:0]   pc_wr_data_q, pc_wr_data_d;
    logic                wr_collide_q, wr_collide_d;

    // Split each write into an array write or a PC redirect.
    logic wr0, wr1, pc_wr0, pc_wr1;
    assign wr0    = we0 && (wa0 != PC_A);
    assign wr1    = we1 && (wa1 != PC_A);
    assign pc_wr0 = we0 && (wa0 == PC_A);
    assign pc_wr1 = we1 && (wa1 == PC_A);

    always_comb begin
        regs_d = regs_q;
        // Port 1 first so port 0 overrides it on a shared address.
        if (wr1) regs_d[wa1] = wd1;
        if (wr0) regs_d[wa0] = wd0;
    end

    always_comb begin
        pend_d = pend_q;
        // Clear before set: a load issuing to the register being filled stays pending.
        if (we1) pend_d[wa1] = 1'b0;
        if (pend_set && (pend_addr != PC_A)) pend_d[pend_addr] = 1'b1;
    end

    always_comb begin
        pc_wr_valid_d = pc_wr0 || pc_wr1;
        pc_wr_data_d  = pc_wr_data_q;
        if (pc_wr0)      pc_wr_data_d = wd0;
        else if (pc_wr1) pc_wr_data_d = wd1;
        wr_collide_d  = we0 && we1 && (wa0 == wa1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q        <= '{default: '0};
            pend_q        <= '0;
            pc_wr_valid_q <= 1'b0;
            pc_wr_data_q  <= '0;
            wr_collide_q  <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            pend_q        <= pend_d;
            pc_wr_valid_q <= pc_wr_valid_d;
            pc_wr_data_q  <= pc_wr_data_d;
            wr_collide_q  <= wr_collide_d;
        end
    end

    assign pc_wr_valid = pc_wr_valid_q;
    assign pc_wr_data  = pc_wr_data_q;
    assign wr_collide  = wr_collide_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs_q[addr];
            busy = pend_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr0 && (wa0 == addr))      data = wd0;
            else if (wr1 && (wa1 == addr)) data = wd1;
            if (we1 && (wa1 == addr))      busy = 1'b0;
`endif
            // The PC alias overrides both the array and any forwarding.
            if (addr == PC_A) begin
                data = pc + PC_OFF;
                busy = 1'b0;
            end
        end

        assign rd[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k]             = busy;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - scoreboard testbench for register_file_mp

module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default-parameter instance (32-bit, 2 read ports)
    logic [7:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    logic [31:0] pc;
    logic        we0, we1, pend_set;
    logic [3:0]  wa0, wa1, pend_addr;
    logic [31:0] wd0, wd1;
    logic        pc_wr_valid, wr_collide;
    logic [31:0] pc_wr_data;

    // Narrow instance (16-bit, 3 read ports)
    logic [11:0] ra_b;
    logic [47:0] rd_b;
    logic [2:0]  rd_busy_b;
    logic [15:0] pc_b;
    logic        we0_b, we1_b, pend_set_b;
    logic [3:0]  wa0_b, wa1_b, pend_addr_b;
    logic [15:0] wd0_b, wd1_b;
    logic        pc_wr_valid_b, wr_collide_b;
    logic [15:0] pc_wr_data_b;

    register_file_mp dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_busy(rd_busy), .pc(pc),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data), .wr_collide(wr_collide)
    );

    register_file_mp #(.DATA_W(16), .NUM_RD(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .ra(ra_b), .rd(rd_b), .rd_busy(rd_busy_b), .pc(pc_b),
        .we0(we0_b), .wa0(wa0_b), .wd0(wd0_b), .we1(we1_b), .wa1(wa1_b), .wd1(wd1_b),
        .pend_set(pend_set_b), .pend_addr(pend_addr_b),
        .pc_wr_valid(pc_wr_valid_b), .pc_wr_data(pc_wr_data_b), .wr_collide(wr_collide_b)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    string       nm_q  [$];
    logic [31:0] obs_q [$];
    logic [31:0] sb_e, sb_o;
    string       sb_n;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic expect_val(input string n, input logic [31:0] e);
        nm_q.push_back(n);
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] v);
        obs_q.push_back(v);
    endtask

    task automatic idle;
        we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0; pend_set = 0; pend_addr = 0;
    endtask

    task automatic idle_b;
        we0_b = 0; wa0_b = 0; wd0_b = 0; we1_b = 0; wa1_b = 0; wd1_b = 0; pend_set_b = 0; pend_addr_b = 0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        ra = {4'd0, 4'd3};
        expect_val("rst_rd3", 32'h0); expect_val("rst_busy", 32'h0);
        expect_val("rst_pcv", 32'h0); expect_val("rst_pcd", 32'h0); expect_val("rst_col", 32'h0);
        #1;
        observe(rd[31:0]); observe(32'(rd_busy)); observe(32'(pc_wr_valid)); observe(pc_wr_data); observe(32'(wr_collide));
        we0 = 1; wa0 = 3; wd0 = 32'hDEAD; we1 = 1; wa1 = 15; wd1 = 32'h44; pend_set = 1; pend_addr = 3;
        expect_val("pre_rd3", 32'hDEAD); expect_val("pre_busy", 32'h1); expect_val("pre_pcv", 32'h1);
        @(posedge clk); #1; idle; #1;
        observe(rd[31:0]); observe(32'(rd_busy)); observe(32'(pc_wr_valid));
        #1 rst_n = 1'b0;
        expect_val("midrst_rd3", 32'h0); expect_val("midrst_busy", 32'h0);
        expect_val("midrst_pcv", 32'h0); expect_val("midrst_pcd", 32'h0);
        #1;
        observe(rd[31:0]); observe(32'(rd_busy)); observe(32'(pc_wr_valid)); observe(pc_wr_data);
        @(negedge clk); rst_n = 1'b1;
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_n = nm_q.pop_front(); checks++;
            if (obs_q.size() > 0) sb_o = obs_q.pop_front(); else sb_o = 'x;
            if (sb_o !== sb_e) begin failures++; $display("FAIL %s got=%h exp=%h", sb_n, sb_o, sb_e); end
        end
    endtask

    task automatic test_pc_alias;
        @(negedge clk);
        pc = 32'h100; ra = {4'd0, 4'd15};
        expect_val("pc_read", 32'h108);
        #1 observe(rd[31:0]);
        we0 = 1; wa0 = 15; wd0 = 32'h200;
        expect_val("pcw_valid", 32'h1); expect_val("pcw_data", 32'h200); expect_val("pcw_r15", 32'h108);
        @(posedge clk); #1; idle; #1;
        observe(32'(pc_wr_valid)); observe(pc_wr_data); observe(rd[31:0]);
        expect_val("pcw_valid_drop", 32'h0); expect_val("pcw_data_hold", 32'h200);
        @(posedge clk); #1;
        observe(32'(pc_wr_valid)); observe(pc_wr_data);
        @(negedge clk);
        we0 = 1; wa0 = 15; wd0 = 32'h300; we1 = 1; wa1 = 15; wd1 = 32'h400;
        expect_val("pcw_both_valid", 32'h1); expect_val("pcw_both_data", 32'h300); expect_val("pcw_both_col", 32'h1);
        @(posedge clk); #1; idle; #1;
        observe(32'(pc_wr_valid)); observe(pc_wr_data); observe(32'(wr_collide));
        @(negedge clk);
        we1 = 1; wa1 = 15; wd1 = 32'h500; pc = 32'hFFFF_FFFC;
        expect_val("pcw_p1_valid", 32'h1); expect_val("pcw_p1_data", 32'h500);
        expect_val("pcw_p1_col", 32'h0); expect_val("pc_wrap32", 32'h4);
        @(posedge clk); #1; idle; #1;
        observe(32'(pc_wr_valid)); observe(pc_wr_data); observe(32'(wr_collide)); observe(rd[31:0]);
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_n = nm_q.pop_front(); checks++;
            if (obs_q.size() > 0) sb_o = obs_q.pop_front(); else sb_o = 'x;
            if (sb_o !== sb_e) begin failures++; $display("FAIL %s got=%h exp=%h", sb_n, sb_o, sb_e); end
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        we0 = 1; we1 = 1; wa0 = 5; wa1 = 5; wd0 = 32'h11; wd1 = 32'h22;
        expect_val("col_r5", 32'h11); expect_val("col_pulse", 32'h1);
        @(posedge clk); #1; idle; ra = {4'd0, 4'd5}; #1;
        observe(rd[31:0]); observe(32'(wr_collide));
        expect_val("col_drop", 32'h0); expect_val("col_r5_hold", 32'h11);
        @(posedge clk); #1;
        observe(32'(wr_collide)); observe(rd[31:0]);
        @(negedge clk);
        we0 = 1; wa0 = 6; wd0 = 32'h66; we1 = 1; wa1 = 8; wd1 = 32'h88;
        expect_val("dual_r6", 32'h66); expect_val("dual_r8", 32'h88); expect_val("dual_nocol", 32'h0);
        @(posedge clk); #1; idle; ra = {4'd8, 4'd6}; #1;
        observe(rd[31:0]); observe(rd[63:32]); observe(32'(wr_collide));
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_n = nm_q.pop_front(); checks++;
            if (obs_q.size() > 0) sb_o = obs_q.pop_front(); else sb_o = 'x;
            if (sb_o !== sb_e) begin failures++; $display("FAIL %s got=%h exp=%h", sb_n, sb_o, sb_e); end
        end
    endtask

    task automatic test_scoreboard;
        @(negedge clk);
        pend_set = 1; pend_addr = 7;
        expect_val("pend_set_busy", 32'h3);
        @(posedge clk); #1; idle; ra = {4'd7, 4'd7}; #1;
        observe(32'(rd_busy));
        @(negedge clk);
        we0 = 1; wa0 = 7; wd0 = 32'h77;
        expect_val("pend_p0_keeps", 32'h3); expect_val("pend_p0_data", 32'h77);
        @(posedge clk); #1; idle; #1;
        observe(32'(rd_busy)); observe(rd[31:0]);
        @(negedge clk);
        we1 = 1; wa1 = 7; wd1 = 32'h55;
        expect_val("pend_clear", 32'h0); expect_val("pend_load_data", 32'h55);
        @(posedge clk); #1; idle; #1;
        observe(32'(rd_busy)); observe(rd[31:0]);
        @(negedge clk);
        we1 = 1; wa1 = 7; wd1 = 32'h66; pend_set = 1; pend_addr = 7;
        expect_val("pend_set_wins", 32'h3); expect_val("pend_set_wins_data", 32'h66);
        @(posedge clk); #1; idle; #1;
        observe(32'(rd_busy)); observe(rd[31:0]);
        @(negedge clk);
        pend_set = 1; pend_addr = 15; ra = {4'd15, 4'd7};
        expect_val("pend_pc_ignored", 32'h1);
        @(posedge clk); #1; idle; #1;
        observe(32'(rd_busy));
        @(negedge clk);
        we1 = 1; wa1 = 7; wd1 = 32'h99;
        @(posedge clk); #1; idle;
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_n = nm_q.pop_front(); checks++;
            if (obs_q.size() > 0) sb_o = obs_q.pop_front(); else sb_o = 'x;
            if (sb_o !== sb_e) begin failures++; $display("FAIL %s got=%h exp=%h", sb_n, sb_o, sb_e); end
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        we0 = 1; wa0 = 2; wd0 = 32'h1234; pend_set = 1; pend_addr = 9;
        @(posedge clk); #1; idle;
        @(negedge clk);
        we0 = 1; wa0 = 2; wd0 = 32'hCAFE; we1 = 1; wa1 = 9; wd1 = 32'h9; ra = {4'd2, 4'd9};
        expect_val("byp_same_cycle", BYP ? 32'hCAFE : 32'h1234);
        expect_val("byp_busy", BYP ? 32'h0 : 32'h1);
        #1 observe(rd[63:32]); observe(32'(rd_busy));
        expect_val("byp_next_cycle", 32'hCAFE); expect_val("byp_busy_next", 32'h0);
        @(posedge clk); #1; idle; #1;
        observe(rd[63:32]); observe(32'(rd_busy));
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_n = nm_q.pop_front(); checks++;
            if (obs_q.size() > 0) sb_o = obs_q.pop_front(); else sb_o = 'x;
            if (sb_o !== sb_e) begin failures++; $display("FAIL %s got=%h exp=%h", sb_n, sb_o, sb_e); end
        end
    endtask

    task automatic test_width;
        @(negedge clk);
        we0_b = 1; wa0_b = 1; wd0_b = 16'hA1A1; we1_b = 1; wa1_b = 2; wd1_b = 16'hB2B2;
        @(posedge clk); #1; idle_b;
        pc_b = 16'hFFFC; ra_b = {4'd15, 4'd2, 4'd1};
        expect_val("w16_p0", 32'hA1A1); expect_val("w16_p1", 32'hB2B2); expect_val("w16_p2_wrap", 32'h0004);
        #1;
        observe(32'(rd_b[15:0])); observe(32'(rd_b[31:16])); observe(32'(rd_b[47:32]));
        ra_b = {4'd1, 4'd15, 4'd2};
        expect_val("w16_p0_b", 32'hB2B2); expect_val("w16_p1_b", 32'h0004); expect_val("w16_p2_b", 32'hA1A1);
        #1;
        observe(32'(rd_b[15:0])); observe(32'(rd_b[31:16])); observe(32'(rd_b[47:32]));
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_n = nm_q.pop_front(); checks++;
            if (obs_q.size() > 0) sb_o = obs_q.pop_front(); else sb_o = 'x;
            if (sb_o !== sb_e) begin failures++; $display("FAIL %s got=%h exp=%h", sb_n, sb_o, sb_e); end
        end
    endtask

    function automatic logic [3:0] pick_addr();
        int t;
        t = $urandom_range(0, 4);
        return (t == 4) ? 4'd15 : 4'(4 + t);
    endfunction

    task automatic test_back_to_back;
        logic [31:0] mem [16];
        logic [15:0] pend;
        logic        prev_pcv, prev_col;
        logic [31:0] prev_pcd, exp_rd;
        logic [1:0]  exp_busy;
        logic [3:0]  a;
        @(negedge clk); idle; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        pend = '0; prev_pcv = 0; prev_col = 0; prev_pcd = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            we0 = 1'($urandom_range(0, 1)); wa0 = pick_addr(); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = pick_addr(); wd1 = $urandom;
            pend_set = 1'($urandom_range(0, 1)); pend_addr = pick_addr();
            pc = $urandom; ra = {pick_addr(), pick_addr()};
            exp_busy = '0;
            for (int k = 0; k < 2; k++) begin
                a = ra[k*4 +: 4];
                exp_rd = mem[a];
                exp_busy[k] = pend[a];
                if (BYP) begin
                    if (we0 && wa0 != 15 && wa0 == a)      exp_rd = wd0;
                    else if (we1 && wa1 != 15 && wa1 == a) exp_rd = wd1;
                    if (we1 && wa1 == a) exp_busy[k] = 1'b0;
                end
                if (a == 15) begin exp_rd = pc + 32'd8; exp_busy[k] = 1'b0; end
                expect_val($sformatf("b2b_rd%0d_c%0d", k, c), exp_rd);
            end
            expect_val($sformatf("b2b_busy_c%0d", c), 32'(exp_busy));
            expect_val($sformatf("b2b_pcv_c%0d", c), 32'(prev_pcv));
            expect_val($sformatf("b2b_pcd_c%0d", c), prev_pcd);
            expect_val($sformatf("b2b_col_c%0d", c), 32'(prev_col));
            #1;
            observe(rd[31:0]); observe(rd[63:32]); observe(32'(rd_busy));
            observe(32'(pc_wr_valid)); observe(pc_wr_data); observe(32'(wr_collide));
            prev_pcv = (we0 && wa0 == 15) || (we1 && wa1 == 15);
            if (we0 && wa0 == 15)      prev_pcd = wd0;
            else if (we1 && wa1 == 15) prev_pcd = wd1;
            prev_col = we0 && we1 && (wa0 == wa1);
            if (we1 && wa1 != 15) mem[wa1] = wd1;
            if (we0 && wa0 != 15) mem[wa0] = wd0;
            if (we1) pend[wa1] = 1'b0;
            if (pend_set && pend_addr != 15) pend[pend_addr] = 1'b1;
        end
        @(negedge clk); idle;
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_n = nm_q.pop_front(); checks++;
            if (obs_q.size() > 0) sb_o = obs_q.pop_front(); else sb_o = 'x;
            if (sb_o !== sb_e) begin failures++; $display("FAIL %s got=%h exp=%h", sb_n, sb_o, sb_e); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle; idle_b;
        ra = '0; pc = '0; ra_b = '0; pc_b = '0;
        repeat (2) @(posedge clk);
        test_reset;
        test_pc_alias;
        test_collision;
        test_scoreboard;
        test_bypass;
        test_width;
        test_back_to_back;
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", obs_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
